// File: rtl/liang_pkg.sv
// Shared types for the execute stage: machine width, uop encoding and the
// registered result entry used by both the output register and the skid slot.
package liang_pkg;

    localparam int XLEN = 32;

    // Functional-unit class of a decoded uop
    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,   // reg-reg arithmetic
        OP_ALUI   = 3'd1,   // reg-imm arithmetic
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_JAL    = 3'd5,
        OP_JALR   = 3'd6
    } fu_op_e;

    // ALU function; the compare group doubles as branch conditions
    typedef enum logic [3:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_AND  = 4'd2,
        F_OR   = 4'd3,
        F_XOR  = 4'd4,
        F_SLL  = 4'd5,
        F_SRL  = 4'd6,
        F_SRA  = 4'd7,
        F_SLT  = 4'd8,
        F_SLTU = 4'd9,
        F_EQ   = 4'd10,
        F_NE   = 4'd11,
        F_LT   = 4'd12,
        F_GE   = 4'd13,
        F_LTU  = 4'd14,
        F_GEU  = 4'd15
    } fu_func_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fu_op_e          fu_op;
        fu_func_e        fu_func;
    } uop_info_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic            we;
        logic            misalign;
        uop_info_t       uop;
    } exu_out_t;

endpackage

// File: rtl/exu_stage_alu.sv
// Integer ALU for the execute stage. Produces the uop result (address for
// loads/stores, link address for jumps) and the branch condition.
module alu
    import liang_pkg::*;
(
    input  fu_op_e          op_i,
    input  fu_func_e        func_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] res_o,
    output logic            jump_o
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] calc;
    logic            cond;

    // Operand select, compare, arithmetic and result mux by functional-unit class
    always_comb begin
        opb  = (op_i == OP_ALU || op_i == OP_BRANCH) ? rs2_i : imm_i;
        cond = 1'b0;
        case (func_i)
            F_EQ:         cond = (rs1_i == opb);
            F_NE:         cond = (rs1_i != opb);
            F_LT, F_SLT:  cond = ($signed(rs1_i) <  $signed(opb));
            F_GE:         cond = ($signed(rs1_i) >= $signed(opb));
            F_LTU, F_SLTU: cond = (rs1_i <  opb);
            F_GEU:        cond = (rs1_i >= opb);
            default:      cond = 1'b0;
        endcase
        case (func_i)
            F_ADD:   calc = rs1_i + opb;
            F_SUB:   calc = rs1_i - opb;
            F_AND:   calc = rs1_i & opb;
            F_OR:    calc = rs1_i | opb;
            F_XOR:   calc = rs1_i ^ opb;
            F_SLL:   calc = rs1_i << opb[SHW-1:0];
            F_SRL:   calc = rs1_i >> opb[SHW-1:0];
            F_SRA:   calc = $unsigned($signed(rs1_i) >>> opb[SHW-1:0]);
            default: calc = {{(XLEN-1){1'b0}}, cond};
        endcase
        case (op_i)
            OP_LOAD, OP_STORE: res_o = rs1_i + imm_i;
            OP_JAL, OP_JALR:   res_o = pc_i + XLEN'(4);
            default:           res_o = calc;
        endcase
        jump_o = cond;
    end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: evaluates one uop per cycle, registers the result for the
// load-store/writeback stage and resolves control flow with an epoch tag so
// wrong-path uops following a redirect are consumed silently.
// Build option: define EXU_SKID_EN to add a skid entry behind the output
// register, giving a registered in_ready_o with no path from out_ready_i.
module exu_stage
    import liang_pkg::*;
#(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  uop_info_t       in_uop_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [4:0]      in_rd_i,
    input  logic            in_we_i,
    input  logic            in_epoch_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output uop_info_t       out_uop_o,
    output logic [XLEN-1:0] out_res_o,
    output logic [XLEN-1:0] out_rs2_o,
    output logic [4:0]      out_rd_o,
    output logic            out_we_o,
    output logic            out_misalign_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    logic [XLEN-1:0] alu_res;
    logic            alu_jump;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            misalign;
    logic            live;
    logic            redirect;
    exu_out_t        entry;

    exu_out_t        out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            epoch_q, epoch_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
`ifdef EXU_SKID_EN
    exu_out_t        skid_q, skid_d;
    logic            skid_valid_q, skid_valid_d;

    assign in_ready_o = !rst_i && !skid_valid_q;
`else
    assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);
`endif

    alu u_alu (
        .op_i   (in_uop_i.fu_op),
        .func_i (in_uop_i.fu_func),
        .pc_i   (in_uop_i.pc),
        .rs1_i  (in_rs1_i),
        .rs2_i  (in_rs2_i),
        .imm_i  (in_uop_i.imm),
        .res_o  (alu_res),
        .jump_o (alu_jump)
    );

    // Jump target, taken/misalign decision and the entry to be registered
    always_comb begin
        tgt_sum  = ((in_uop_i.fu_op == OP_JALR) ? in_rs1_i : in_uop_i.pc) + in_uop_i.imm;
        target   = (in_uop_i.fu_op == OP_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
        taken    = (in_uop_i.fu_op == OP_JAL) || (in_uop_i.fu_op == OP_JALR) ||
                   ((in_uop_i.fu_op == OP_BRANCH) && alu_jump);
        misalign = taken && MISALIGN_CHK && target[1];
        // flush kills a same-cycle handshake, so it can neither issue nor redirect
        live     = in_valid_i && in_ready_o && !flush_i && (in_epoch_i == epoch_q);
        redirect = live && taken && !misalign;
        entry.res      = alu_res;
        entry.rs2      = in_rs2_i;
        entry.rd       = in_rd_i;
        entry.we       = in_we_i && (in_uop_i.fu_op != OP_BRANCH) && !misalign;
        entry.misalign = misalign;
        entry.uop      = in_uop_i;
    end

    // Next-state for output/skid storage, redirect pulse and epoch
    always_comb begin
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        redir_valid_d = redirect;
        redir_pc_d    = redirect ? target : redir_pc_q;
        epoch_d       = epoch_q ^ redirect;
`ifdef EXU_SKID_EN
        skid_d        = skid_q;
        skid_valid_d  = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                // skid is older than anything arriving now
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = live;
                if (live) skid_d = entry;
            end else begin
                out_valid_d = live;
                if (live) out_d = entry;
            end
        end else if (live) begin
            skid_d       = entry;
            skid_valid_d = 1'b1;
        end
`else
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (live) begin
            out_d       = entry;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            epoch_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
`ifdef EXU_SKID_EN
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
`endif
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            epoch_q       <= epoch_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
`ifdef EXU_SKID_EN
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
`endif
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_uop_o        = out_q.uop;
    assign out_res_o        = out_q.res;
    assign out_rs2_o        = out_q.rs2;
    assign out_rd_o         = out_q.rd;
    assign out_we_o         = out_q.we;
    assign out_misalign_o   = out_q.misalign;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;

endmodule

// File: tb/tb_exu_stage.sv
// Bench for exu_stage: directed scenarios plus a randomized stream, checked
// by a scoreboard fed from a behavioural model of the execute rules.
module tb_exu_stage;
    import liang_pkg::*;

    localparam bit MCHK = 1'b1;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    uop_info_t   in_uop_i = '0;
    logic [31:0] in_rs1_i = '0, in_rs2_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        in_we_i = 1'b0;
    logic        in_epoch_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    uop_info_t   out_uop_o;
    logic [31:0] out_res_o, out_rs2_o;
    logic [4:0]  out_rd_o;
    logic        out_we_o, out_misalign_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    exu_stage #(.MISALIGN_CHK(MCHK)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_uop_i(in_uop_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
        .in_we_i(in_we_i), .in_epoch_i(in_epoch_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_uop_o(out_uop_o),
        .out_res_o(out_res_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
        .out_we_o(out_we_o), .out_misalign_o(out_misalign_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exu_out_t    exp_q[$];
    logic        m_epoch = 1'b0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;
    int          acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: what the stage must do with one live uop, from the ISA-level rules
    function automatic void model_uop(input uop_info_t u, input logic [31:0] a, input logic [31:0] r2,
                                      input logic [4:0] rd, input logic we,
                                      output exu_out_t e, output logic redir, output logic [31:0] tgt);
        logic [31:0] b, res;
        logic        c, tk, mis;
        b = (u.fu_op == OP_ALU || u.fu_op == OP_BRANCH) ? r2 : u.imm;
        case (u.fu_func)
            F_EQ:          c = (a == b);
            F_NE:          c = (a != b);
            F_LT, F_SLT:   c = ($signed(a) < $signed(b));
            F_GE:          c = !($signed(a) < $signed(b));
            F_LTU, F_SLTU: c = (a < b);
            F_GEU:         c = !(a < b);
            default:       c = 1'b0;
        endcase
        case (u.fu_func)
            F_ADD:   res = a + b;
            F_SUB:   res = a - b;
            F_AND:   res = a & b;
            F_OR:    res = a | b;
            F_XOR:   res = a ^ b;
            F_SLL:   res = a << b[4:0];
            F_SRL:   res = a >> b[4:0];
            F_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
            default: res = c ? 32'd1 : 32'd0;
        endcase
        if (u.fu_op == OP_LOAD || u.fu_op == OP_STORE) res = a + u.imm;
        if (u.fu_op == OP_JAL || u.fu_op == OP_JALR)   res = u.pc + 32'd4;
        tk  = (u.fu_op == OP_JAL) || (u.fu_op == OP_JALR) || (u.fu_op == OP_BRANCH && c);
        tgt = (u.fu_op == OP_JALR) ? ((a + u.imm) & 32'hFFFF_FFFE) : (u.pc + u.imm);
        mis = tk && MCHK && tgt[1];
        e.res = res; e.rs2 = r2; e.rd = rd; e.uop = u;
        e.we = we && (u.fu_op != OP_BRANCH) && !mis;
        e.misalign = mis;
        redir = tk && !mis;
    endfunction

    // Scoreboard producer: observes handshakes and pushes expected results
    always begin
        @(negedge clk);
        #1;
        if (rst_i) begin
            exp_q.delete();
            m_epoch = 1'b0;
            exp_rv  = 1'b0;
        end else begin
            exu_out_t    e;
            logic        r;
            logic [31:0] t;
            logic        rv_next;
            rv_next = 1'b0;
            if (flush_i) begin
                exp_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                acc_cnt++;
                if (in_epoch_i == m_epoch) begin
                    model_uop(in_uop_i, in_rs1_i, in_rs2_i, in_rd_i, in_we_i, e, r, t);
                    exp_q.push_back(e);
                    if (r) begin
                        rv_next = 1'b1;
                        exp_rpc = t;
                        m_epoch = ~m_epoch;
                    end
                end
            end
            exp_rv = rv_next;
        end
    end

    // Scoreboard consumer: checks redirects every cycle and outputs on transfer
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("redirect_valid", 32'(redirect_valid_o), 32'(exp_rv));
            if (exp_rv) chk("redirect_pc", redirect_pc_o, exp_rpc);
            if (out_valid_o && out_ready_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: got res=%h pc=%h expected no output", out_res_o, out_uop_o.pc);
                end else begin
                    exu_out_t g, w;
                    w = exp_q.pop_front();
                    g.res = out_res_o; g.rs2 = out_rs2_o; g.rd = out_rd_o;
                    g.we = out_we_o; g.misalign = out_misalign_o; g.uop = out_uop_o;
                    if (g !== w) begin
                        fails++;
                        $display("FAIL out_entry: got res=%h rs2=%h rd=%0d we=%b mis=%b pc=%h op=%0d expected res=%h rs2=%h rd=%0d we=%b mis=%b pc=%h op=%0d",
                                 g.res, g.rs2, g.rd, g.we, g.misalign, g.uop.pc, g.uop.fu_op,
                                 w.res, w.rs2, w.rd, w.we, w.misalign, w.uop.pc, w.uop.fu_op);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input fu_op_e op, input fu_func_e f, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic we, input logic ep);
        in_uop_i.fu_op = op; in_uop_i.fu_func = f; in_uop_i.pc = pc; in_uop_i.imm = imm;
        in_rs1_i = a; in_rs2_i = b; in_rd_i = rd; in_we_i = we; in_epoch_i = ep;
    endtask

    // Present one uop and hold it until accepted (bounded)
    task automatic send(input fu_op_e op, input fu_func_e f, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic we, input logic ep);
        int n;
        set_in(op, f, pc, imm, a, b, rd, we, ep);
        in_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no in_ready_o within 50 cycles expected acceptance");
        end
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        logic [31:0] hold_res;
        logic [3:0]  fv;
        // reset state
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready_o), 0);
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_redirect", 32'(redirect_valid_o), 0);
        chk("rst_res", out_res_o, 0);
        rst_i = 1'b0;
        step();

        // ADDI 5 + -3
        send(OP_ALUI, F_ADD, 32'h0, 32'hFFFF_FFFD, 32'd5, 32'd0, 5'd1, 1'b1, m_epoch);
        chk("addi_valid", 32'(out_valid_o), 1);
        chk("addi_res", out_res_o, 32'd2);
        chk("addi_we", 32'(out_we_o), 1);
        chk("addi_redir", 32'(redirect_valid_o), 0);
        step();

        // BEQ taken, then a stale-epoch uop is dropped
        begin
            logic old_ep;
            old_ep = m_epoch;
            send(OP_BRANCH, F_EQ, 32'h100, 32'h20, 32'd7, 32'd7, 5'd0, 1'b0, old_ep);
            chk("beq_redir", 32'(redirect_valid_o), 1);
            chk("beq_pc", redirect_pc_o, 32'h120);
            chk("beq_we", 32'(out_we_o), 0);
            send(OP_ALUI, F_ADD, 32'h104, 32'd1, 32'd1, 32'd0, 5'd3, 1'b1, old_ep);
            chk("stale_dropped", 32'(out_valid_o), 0);
            chk("beq_pulse_once", 32'(redirect_valid_o), 0);
        end

        // JALR cases
        send(OP_JALR, F_ADD, 32'h200, 32'd2, 32'h1001, 32'd0, 5'd1, 1'b1, m_epoch);
        chk("jalr_mis1_flag", 32'(out_misalign_o), 1);
        chk("jalr_mis1_res", out_res_o, 32'h204);
        chk("jalr_mis1_we", 32'(out_we_o), 0);
        chk("jalr_mis1_redir", 32'(redirect_valid_o), 0);
        send(OP_JALR, F_ADD, 32'h200, 32'd5, 32'h1000, 32'd0, 5'd1, 1'b1, m_epoch);
        chk("jalr_ok_redir", 32'(redirect_valid_o), 1);
        chk("jalr_ok_pc", redirect_pc_o, 32'h1004);
        chk("jalr_ok_flag", 32'(out_misalign_o), 0);
        chk("jalr_ok_we", 32'(out_we_o), 1);
        send(OP_JALR, F_ADD, 32'h200, 32'd3, 32'h1000, 32'd0, 5'd1, 1'b1, m_epoch);
        chk("jalr_mis3_flag", 32'(out_misalign_o), 1);
        send(OP_JALR, F_ADD, 32'h200, 32'd6, 32'h1000, 32'd0, 5'd1, 1'b1, m_epoch);
        chk("jalr_mis6_flag", 32'(out_misalign_o), 1);
        chk("jalr_mis6_redir", 32'(redirect_valid_o), 0);
        step();

        // Downstream stall with a continuous input stream
        acc0 = acc_cnt;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(OP_ALUI, F_ADD, 32'h500 + 32'(4*i), 32'd1, 32'd100 + 32'(i), 32'd0, 5'(i+4), 1'b1, m_epoch);
            step();
            chk("stall_valid", 32'(out_valid_o), 1);
            chk("stall_hold", out_res_o, 32'd101);
        end
        in_valid_i = 1'b0;
`ifdef EXU_SKID_EN
        chk("stall_accepts", 32'(acc_cnt - acc0), 2);
        chk("stall_in_ready", 32'(in_ready_o), 0);
`else
        chk("stall_accepts", 32'(acc_cnt - acc0), 1);
        chk("stall_in_ready", 32'(in_ready_o), 0);
`endif
        out_ready_i = 1'b1;
        repeat (4) step();

        // Flush against a same-cycle handshake and pending redirect
        send(OP_JAL, F_ADD, 32'h300, 32'h40, 32'd0, 32'd0, 5'd2, 1'b1, m_epoch);
        chk("flush_pre_redir", 32'(redirect_valid_o), 1);
        chk("flush_pre_pc", redirect_pc_o, 32'h340);
        set_in(OP_JAL, F_ADD, 32'h340, 32'h80, 32'd0, 32'd0, 5'd3, 1'b1, m_epoch);
        flush_i = 1'b1; in_valid_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_out_valid", 32'(out_valid_o), 0);
        chk("flush_redirect", 32'(redirect_valid_o), 0);
        send(OP_ALUI, F_ADD, 32'h340, 32'd1, 32'd9, 32'd0, 5'd4, 1'b1, m_epoch);
        chk("flush_epoch_kept", 32'(out_valid_o), 1);
        chk("flush_after_res", out_res_o, 32'd10);
        step();

        // Reset in the middle of a stall with a non-zero epoch
        send(OP_JAL, F_ADD, 32'h400, 32'h8, 32'd0, 32'd0, 5'd1, 1'b1, m_epoch);
        step();
        out_ready_i = 1'b0;
        send(OP_ALUI, F_ADD, 32'h408, 32'h11, 32'h55, 32'h77, 5'd6, 1'b1, m_epoch);
        hold_res = out_res_o;
        chk("pre_rst_valid", 32'(out_valid_o), 1);
        chk("pre_rst_res", hold_res, 32'h66);
        rst_i = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid_o), 0);
        chk("mid_rst_redir", 32'(redirect_valid_o), 0);
        chk("mid_rst_mis", 32'(out_misalign_o), 0);
        chk("mid_rst_res", out_res_o, 0);
        chk("mid_rst_rs2", out_rs2_o, 0);
        chk("mid_rst_rpc", redirect_pc_o, 0);
        chk("mid_rst_ready", 32'(in_ready_o), 0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        send(OP_ALUI, F_ADD, 32'h0, 32'd3, 32'd4, 32'd0, 5'd1, 1'b1, 1'b0);
        chk("post_rst_epoch0", 32'(out_valid_o), 1);
        chk("post_rst_res", out_res_o, 32'd7);

        // Randomized stream
        for (int c = 0; c < 1500; c++) begin
            fu_op_e      op;
            logic [31:0] a, b, imm;
            op = fu_op_e'(3'($urandom_range(0, 6)));
            fv = (op == OP_BRANCH) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom);
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            set_in(op, fu_func_e'(fv), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, imm, a, b,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? ~m_epoch : m_epoch);
            in_valid_i  = ($urandom_range(0, 4) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        repeat (6) step();
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
